// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, loads IF/ID, and handles stalls, redirects and fetch faults.
// Optional build macro FETCH_STALL_CNT_EN adds a saturating stall-cycle counter.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [63:0]      redirect_pc_i,
  input  logic [31:0]      imem_instr_i,
  input  logic             imem_inv_addr_i,
  output logic [63:0]      pc_o,
  output logic [63:0]      if_id_pc_o,
  output logic [31:0]      if_id_instr_o,
  output logic             if_id_valid_o,
  output logic             fault_o,
  output logic [63:0]      fault_pc_o,
  output logic [CNT_W-1:0] fetch_count_o,
  output logic [CNT_W-1:0] stall_count_o
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [63:0]      pc_d, if_id_pc_d, fault_pc_d;
  logic [31:0]      if_id_instr_d;
  logic             if_id_valid_d, fault_d;
  logic [CNT_W-1:0] fetch_count_d;
  logic             stall_cycle;

  // NOTE: every next-state value gets a hold default before the case, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_o;
    if_id_pc_d    = if_id_pc_o;
    if_id_instr_d = if_id_instr_o;
    if_id_valid_d = if_id_valid_o;
    fault_d       = fault_o;
    fault_pc_d    = fault_pc_o;
    fetch_count_d = fetch_count_o;
    stall_cycle   = 1'b0;

    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid_i) begin
          pc_d          = redirect_pc_i;
          if_id_pc_d    = 64'h0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else if (stall_i) begin
          stall_cycle = 1'b1;
        end else if (imem_inv_addr_i) begin
          state_d       = HALT;
          fault_d       = 1'b1;
          fault_pc_d    = pc_o;
          if_id_pc_d    = 64'h0;
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
        end else begin
          if_id_pc_d    = pc_o;
          if_id_instr_d = imem_instr_i;
          if_id_valid_d = 1'b1;
          pc_d          = pc_o + 64'd4;
          if (fetch_count_o != CNT_MAX) fetch_count_d = fetch_count_o + CNT_ONE;
        end
      end
      HALT: begin
        // Only a redirect leaves HALT; fault_pc_o is kept for post-mortem.
        if (redirect_valid_i) begin
          pc_d    = redirect_pc_i;
          fault_d = 1'b0;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_o          <= RESET_PC;
      if_id_pc_o    <= 64'h0;
      if_id_instr_o <= NOP_INSTR;
      if_id_valid_o <= 1'b0;
      fault_o       <= 1'b0;
      fault_pc_o    <= 64'h0;
      fetch_count_o <= '0;
    end else begin
      state_q       <= state_d;
      pc_o          <= pc_d;
      if_id_pc_o    <= if_id_pc_d;
      if_id_instr_o <= if_id_instr_d;
      if_id_valid_o <= if_id_valid_d;
      fault_o       <= fault_d;
      fault_pc_o    <= fault_pc_d;
      fetch_count_o <= fetch_count_d;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_o <= '0;
    end else if (stall_cycle && stall_count_o != CNT_MAX) begin
      stall_count_o <= stall_count_o + CNT_ONE;
    end
  end
`else
  logic unused_stall_cycle;
  assign unused_stall_cycle = stall_cycle;
  assign stall_count_o      = '0;
`endif

endmodule
